// File: rtl/pong_match_if.sv
// Bundles the match controller's pulse/level inputs and registered outputs.
// The master side drives the key/frame/goal inputs.
// The slave side is the match controller itself.
interface pong_match_if #(
  parameter int SCORE_W = 4
);
  logic               i_Frame_Tick;
  logic               i_Space;
  logic               i_P1_Point;
  logic               i_P2_Point;
  logic [2:0]         o_State;
  logic               o_Ball_Hold;
  logic               o_Ball_Launch;
  logic               o_Ball_Freeze;
  logic               o_Serve_Dir;
  logic               o_Paddle_En;
  logic [SCORE_W-1:0] o_P1_Score;
  logic [SCORE_W-1:0] o_P2_Score;
  logic [1:0]         o_Winner;

  modport master (
    output i_Frame_Tick, i_Space, i_P1_Point, i_P2_Point,
    input  o_State, o_Ball_Hold, o_Ball_Launch, o_Ball_Freeze, o_Serve_Dir,
           o_Paddle_En, o_P1_Score, o_P2_Score, o_Winner
  );

  modport slave (
    input  i_Frame_Tick, i_Space, i_P1_Point, i_P2_Point,
    output o_State, o_Ball_Hold, o_Ball_Launch, o_Ball_Freeze, o_Serve_Dir,
           o_Paddle_En, o_P1_Score, o_P2_Score, o_Winner
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: IDLE -> SERVE -> PLAY -> POINT/OVER, with scoring.
// The optional pause feature is enabled by defining PONG_PAUSE_EN; it adds
// the PAUSED state that freezes the ball and paddles.
//
// Inputs are single-cycle pulses (i_Frame_Tick, i_Space) or levels
// (i_P1_Point, i_P2_Point). There is no valid/ready handshake: every pulse
// is consumed in the cycle it is high, or it is dropped if the current
// state does not use it.
// All outputs come straight from registers. The next values are computed
// from the next state in one combinational block.
module pong_match_ctrl #(
  parameter int WIN_SCORE          = 7,
  parameter int SCORE_W            = 4,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_HOLD_FRAMES  = 90
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  pong_match_if.slave io_Match
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SERVE  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_POINT  = 3'd3,
    ST_OVER   = 3'd4,
    ST_PAUSED = 3'd5
  } state_t;

  localparam logic [7:0]         SERVE_LOAD = 8'(SERVE_DELAY_FRAMES);
  localparam logic [7:0]         POINT_LOAD = 8'(POINT_HOLD_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  state_t             r_state;
  logic [7:0]         r_count;
  logic [SCORE_W-1:0] r_p1_score;
  logic [SCORE_W-1:0] r_p2_score;
  logic [1:0]         r_winner;
  logic               r_serve_dir;
  logic               r_hold;
  logic               r_launch;
  logic               r_paddle_en;
  logic               r_p1_prev;
  logic               r_p2_prev;

  state_t             w_state_nxt;
  logic [7:0]         w_count_nxt;
  logic [SCORE_W-1:0] w_p1_score_nxt;
  logic [SCORE_W-1:0] w_p2_score_nxt;
  logic [1:0]         w_winner_nxt;
  logic               w_serve_dir_nxt;
  logic               w_hold_nxt;
  logic               w_launch_nxt;
  logic               w_paddle_en_nxt;
  logic               w_p1_edge;
  logic               w_p2_edge;
  logic [SCORE_W-1:0] w_p1_inc;
  logic [SCORE_W-1:0] w_p2_inc;

  assign w_p1_edge = io_Match.i_P1_Point & ~r_p1_prev;
  assign w_p2_edge = io_Match.i_P2_Point & ~r_p2_prev;
  assign w_p1_inc  = r_p1_score + SCORE_W'(1);
  assign w_p2_inc  = r_p2_score + SCORE_W'(1);

  // Next-state, counter, score and output decode; defaults hold everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_count_nxt     = r_count;
    w_p1_score_nxt  = r_p1_score;
    w_p2_score_nxt  = r_p2_score;
    w_winner_nxt    = r_winner;
    w_serve_dir_nxt = r_serve_dir;

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (io_Match.i_Space) begin
          w_state_nxt    = ST_SERVE;
          w_count_nxt    = SERVE_LOAD;
          w_p1_score_nxt = '0;
          w_p2_score_nxt = '0;
          w_winner_nxt   = 2'b00;
        end
      end
      ST_SERVE: begin
        if (r_count == 8'd0) begin
          w_state_nxt = ST_PLAY;
        end else if (io_Match.i_Frame_Tick) begin
          w_count_nxt = r_count - 8'd1;
        end
      end
      ST_PLAY: begin
        // Player 1 wins a same-cycle tie; player 2's edge is dropped.
        if (w_p1_edge) begin
          w_p1_score_nxt  = w_p1_inc;
          w_serve_dir_nxt = 1'b1;
          if (w_p1_inc == WIN_VAL) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = 2'b01;
          end else begin
            w_state_nxt = ST_POINT;
            w_count_nxt = POINT_LOAD;
          end
        end else if (w_p2_edge) begin
          w_p2_score_nxt  = w_p2_inc;
          w_serve_dir_nxt = 1'b0;
          if (w_p2_inc == WIN_VAL) begin
            w_state_nxt  = ST_OVER;
            w_winner_nxt = 2'b10;
          end else begin
            w_state_nxt = ST_POINT;
            w_count_nxt = POINT_LOAD;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (io_Match.i_Space) begin
          w_state_nxt = ST_PAUSED;
        end
`endif
      end
      ST_POINT: begin
        if (r_count == 8'd0) begin
          w_state_nxt = ST_SERVE;
          w_count_nxt = SERVE_LOAD;
        end else if (io_Match.i_Frame_Tick) begin
          w_count_nxt = r_count - 8'd1;
        end
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSED: begin
        if (io_Match.i_Space) begin
          w_state_nxt = ST_PLAY;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the state being entered so they line up with it.
    w_hold_nxt      = (w_state_nxt != ST_PLAY) && (w_state_nxt != ST_PAUSED);
    w_paddle_en_nxt = (w_state_nxt != ST_OVER) && (w_state_nxt != ST_PAUSED);
    // Launch only when coming from SERVE, so a resume from PAUSED gives no pulse.
    w_launch_nxt    = (w_state_nxt == ST_PLAY) && (r_state == ST_SERVE);
  end

  // State, counter, score and output registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= ST_IDLE;
      r_count     <= 8'd0;
      r_p1_score  <= '0;
      r_p2_score  <= '0;
      r_winner    <= 2'b00;
      r_serve_dir <= 1'b0;
      r_hold      <= 1'b1;
      r_launch    <= 1'b0;
      r_paddle_en <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_count     <= w_count_nxt;
      r_p1_score  <= w_p1_score_nxt;
      r_p2_score  <= w_p2_score_nxt;
      r_winner    <= w_winner_nxt;
      r_serve_dir <= w_serve_dir_nxt;
      r_hold      <= w_hold_nxt;
      r_launch    <= w_launch_nxt;
      r_paddle_en <= w_paddle_en_nxt;
    end
  end

  // Goal-level history sampled every cycle, so a level held across
  // POINT/SERVE cannot fire again on return to PLAY.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_p1_prev <= 1'b0;
      r_p2_prev <= 1'b0;
    end else begin
      r_p1_prev <= io_Match.i_P1_Point;
      r_p2_prev <= io_Match.i_P2_Point;
    end
  end

`ifdef PONG_PAUSE_EN
  logic r_freeze;

  // Ball freeze follows entry into PAUSED.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_freeze <= 1'b0;
    end else begin
      r_freeze <= (w_state_nxt == ST_PAUSED);
    end
  end

  assign io_Match.o_Ball_Freeze = r_freeze;
`else
  assign io_Match.o_Ball_Freeze = 1'b0;
`endif

  assign io_Match.o_State       = r_state;
  assign io_Match.o_Ball_Hold   = r_hold;
  assign io_Match.o_Ball_Launch = r_launch;
  assign io_Match.o_Serve_Dir   = r_serve_dir;
  assign io_Match.o_Paddle_En   = r_paddle_en;
  assign io_Match.o_P1_Score    = r_p1_score;
  assign io_Match.o_P2_Score    = r_p2_score;
  assign io_Match.o_Winner      = r_winner;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Testbench for pong_match_ctrl with WIN_SCORE=3, SERVE_DELAY_FRAMES=2 and
// POINT_HOLD_FRAMES=3. Each vector gives the inputs for one cycle and the
// outputs expected just after the next rising edge.
module tb_pong_match_ctrl;

  localparam int SW = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                         S_POINT = 3'd3, S_OVER = 3'd4, S_PAUSED = 3'd5;

  typedef struct {
    logic          tick, space, p1, p2;
    logic [2:0]    st;
    logic          hold, launch, freeze, dir, pad;
    logic [SW-1:0] s1, s2;
    logic [1:0]    win;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[$];

  pong_match_if #(.SCORE_W(SW)) bus ();

  pong_match_ctrl #(
    .WIN_SCORE(3), .SCORE_W(SW), .SERVE_DELAY_FRAMES(2), .POINT_HOLD_FRAMES(3)
  ) dut (
    .i_Clock  (clk),
    .i_Reset  (rst),
    .io_Match (bus)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic t, input logic s, input logic p1, input logic p2);
    bus.i_Frame_Tick = t;
    bus.i_Space      = s;
    bus.i_P1_Point   = p1;
    bus.i_P2_Point   = p2;
  endtask

  task automatic add(input int n, input logic t, input logic s, input logic p1,
                     input logic p2, input logic [2:0] st, input logic h,
                     input logic l, input logic f, input logic d, input logic pad,
                     input logic [SW-1:0] s1, input logic [SW-1:0] s2,
                     input logic [1:0] w);
    vec_t v;
    v.tick = t; v.space = s; v.p1 = p1; v.p2 = p2; v.st = st;
    v.hold = h; v.launch = l; v.freeze = f; v.dir = d; v.pad = pad;
    v.s1 = s1; v.s2 = s2; v.win = w;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check_all(input int idx, input vec_t v);
    check("state",   idx, 32'(bus.o_State),       32'(v.st));
    check("hold",    idx, 32'(bus.o_Ball_Hold),   32'(v.hold));
    check("launch",  idx, 32'(bus.o_Ball_Launch), 32'(v.launch));
    check("freeze",  idx, 32'(bus.o_Ball_Freeze), 32'(v.freeze));
    check("dir",     idx, 32'(bus.o_Serve_Dir),   32'(v.dir));
    check("paddle",  idx, 32'(bus.o_Paddle_En),   32'(v.pad));
    check("p1score", idx, 32'(bus.o_P1_Score),    32'(v.s1));
    check("p2score", idx, 32'(bus.o_P2_Score),    32'(v.s2));
    check("winner",  idx, 32'(bus.o_Winner),      32'(v.win));
  endtask

  // Apply each vector at a falling edge, compare at the next falling edge.
  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].tick, vecs[i].space, vecs[i].p1, vecs[i].p2);
      @(negedge clk);
      check_all(i, vecs[i]);
    end
    vecs.delete();
  endtask

  task automatic check_reset_values(input int idx);
    vec_t r;
    r.tick = 0; r.space = 0; r.p1 = 0; r.p2 = 0; r.st = S_IDLE;
    r.hold = 1; r.launch = 0; r.freeze = 0; r.dir = 0; r.pad = 1;
    r.s1 = 0; r.s2 = 0; r.win = 2'b00;
    check_all(idx, r);
  endtask

  initial begin
    drive(0, 0, 0, 0);
    @(negedge clk);
    check_reset_values(1000);
    rst = 1'b0;

    // Serve: Space -> SERVE, two ticks, then PLAY with one launch pulse.
    add(1, 0,1,0,0, S_SERVE, 1,0,0,0,1, 0,0, 2'b00);
    add(2, 1,0,0,0, S_SERVE, 1,0,0,0,1, 0,0, 2'b00);
    add(1, 0,0,0,0, S_PLAY,  0,1,0,0,1, 0,0, 2'b00);
    add(1, 0,0,0,0, S_PLAY,  0,0,0,0,1, 0,0, 2'b00);
    // Single P1 point, Space ignored in POINT, hold 3 ticks, serve, play.
    add(1, 0,0,1,0, S_POINT, 1,0,0,1,1, 1,0, 2'b00);
    add(1, 1,0,1,0, S_POINT, 1,0,0,1,1, 1,0, 2'b00);
    add(1, 0,1,1,0, S_POINT, 1,0,0,1,1, 1,0, 2'b00);
    add(2, 1,0,0,0, S_POINT, 1,0,0,1,1, 1,0, 2'b00);
    add(1, 0,0,0,0, S_SERVE, 1,0,0,1,1, 1,0, 2'b00);
    add(2, 1,0,0,0, S_SERVE, 1,0,0,1,1, 1,0, 2'b00);
    add(1, 0,0,0,0, S_PLAY,  0,1,0,1,1, 1,0, 2'b00);
    // Player 2 scores three times and wins.
    for (int k = 1; k <= 2; k++) begin
      add(1, 0,0,0,1, S_POINT, 1,0,0,0,1, 1,SW'(k), 2'b00);
      add(3, 1,0,0,0, S_POINT, 1,0,0,0,1, 1,SW'(k), 2'b00);
      add(1, 0,0,0,0, S_SERVE, 1,0,0,0,1, 1,SW'(k), 2'b00);
      add(2, 1,0,0,0, S_SERVE, 1,0,0,0,1, 1,SW'(k), 2'b00);
      add(1, 0,0,0,0, S_PLAY,  0,1,0,0,1, 1,SW'(k), 2'b00);
    end
    add(1, 0,0,0,1, S_OVER,  1,0,0,0,0, 1,3, 2'b10);
    add(1, 1,0,0,0, S_OVER,  1,0,0,0,0, 1,3, 2'b10);
    add(1, 0,1,0,0, S_SERVE, 1,0,0,0,1, 0,0, 2'b00);
    // Simultaneous edges: P1 only; held levels add nothing on return to PLAY.
    add(2, 1,0,0,0, S_SERVE, 1,0,0,0,1, 0,0, 2'b00);
    add(1, 0,0,0,0, S_PLAY,  0,1,0,0,1, 0,0, 2'b00);
    add(1, 0,0,1,1, S_POINT, 1,0,0,1,1, 1,0, 2'b00);
    add(3, 1,0,1,1, S_POINT, 1,0,0,1,1, 1,0, 2'b00);
    add(1, 0,0,1,1, S_SERVE, 1,0,0,1,1, 1,0, 2'b00);
    add(2, 1,0,1,1, S_SERVE, 1,0,0,1,1, 1,0, 2'b00);
    add(1, 0,0,1,1, S_PLAY,  0,1,0,1,1, 1,0, 2'b00);
    add(1, 0,0,1,1, S_PLAY,  0,0,0,1,1, 1,0, 2'b00);
    // Build up 2/1 and park in POINT for the async reset check.
    add(1, 0,0,0,0, S_PLAY,  0,0,0,1,1, 1,0, 2'b00);
    add(1, 0,0,1,0, S_POINT, 1,0,0,1,1, 2,0, 2'b00);
    add(3, 1,0,1,0, S_POINT, 1,0,0,1,1, 2,0, 2'b00);
    add(1, 0,0,0,0, S_SERVE, 1,0,0,1,1, 2,0, 2'b00);
    add(2, 1,0,0,0, S_SERVE, 1,0,0,1,1, 2,0, 2'b00);
    add(1, 0,0,0,0, S_PLAY,  0,1,0,1,1, 2,0, 2'b00);
    add(1, 0,0,0,1, S_POINT, 1,0,0,0,1, 2,1, 2'b00);
    add(1, 1,0,0,1, S_POINT, 1,0,0,0,1, 2,1, 2'b00);
    run_vecs();

    // Async reset mid-POINT: outputs return to reset values with no clock edge.
    drive(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 check_reset_values(2000);
    @(negedge clk);
    check_reset_values(2001);
    rst = 1'b0;

    // Space in PLAY: pause/resume when enabled, otherwise ignored.
    add(1, 0,1,0,0, S_SERVE, 1,0,0,0,1, 0,0, 2'b00);
    add(2, 1,0,0,0, S_SERVE, 1,0,0,0,1, 0,0, 2'b00);
    add(1, 0,0,0,0, S_PLAY,  0,1,0,0,1, 0,0, 2'b00);
`ifdef PONG_PAUSE_EN
    add(1, 0,1,0,0, S_PAUSED, 0,0,1,0,0, 0,0, 2'b00);
    add(1, 0,0,1,0, S_PAUSED, 0,0,1,0,0, 0,0, 2'b00);
    add(1, 0,1,0,0, S_PLAY,   0,0,0,0,1, 0,0, 2'b00);
`else
    add(1, 0,1,0,0, S_PLAY,   0,0,0,0,1, 0,0, 2'b00);
`endif
    add(1, 0,0,1,0, S_POINT, 1,0,0,1,1, 1,0, 2'b00);
    run_vecs();

    drive(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
